// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding,
// parity-type constants, data width and a parity helper.
package uart_tx_pkg;

    localparam int DATA_WIDTH = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Index of the last data bit; the bit counter wraps after reaching it
    localparam logic [2:0] BIT_CNT_LAST = 3'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Even parity is the plain XOR of the data bits; odd parity is its inverse
    function automatic logic calcParity(input logic [DATA_WIDTH-1:0] data,
                                        input logic parTyp);
        return (^data) ^ (parTyp == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_par_calc.sv
// Parity generator for the UART transmitter. Works on the latched frame
// data so the parity bit cannot change while a frame is being sent.
module par_calc
    import uart_tx_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_parTyp,
    output logic                  o_parity
);

    logic w_parity;

    // Combinational parity of the latched byte, selected even/odd by i_parTyp
    always_comb begin
        w_parity = calcParity(i_data, i_parTyp);
    end

    assign o_parity = w_parity;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one serial bit per CLK cycle, frame is
// start(0), 8 data bits LSB first, optional parity, stop(1).
// A new request is taken in IDLE or in the STOP cycle, so frames can run
// back-to-back with no idle gap and no drop of busy.
module uart_tx
    import uart_tx_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  busy
);

    state_t                  r_state;
    logic [2:0]              r_bitCnt;
    logic [DATA_WIDTH-1:0]   r_data;
    logic                    r_parEn;
    logic                    r_parTyp;
    logic                    r_txOut;
    logic                    r_busy;
    logic                    w_parity;

    par_calc u_parCalc (
        .i_data   (r_data),
        .i_parTyp (r_parTyp),
        .o_parity (w_parity)
    );

    assign TX_OUT = r_txOut;
    assign busy   = r_busy;

    // FSM, serializer and output mux: each edge decides the next state and
    // registers the line level that belongs to it, so TX_OUT/busy are glitch-free
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= IDLE;
            r_bitCnt <= 3'd0;
            r_data   <= '0;
            r_parEn  <= 1'b0;
            r_parTyp <= 1'b0;
            r_txOut  <= 1'b1;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, STOP: begin
                    if (DATA_VALID) begin
                        r_data   <= P_DATA;
                        r_parEn  <= PAR_EN;
                        r_parTyp <= PAR_TYP;
                        r_bitCnt <= 3'd0;
                        r_state  <= START;
                        r_txOut  <= 1'b0;
                        r_busy   <= 1'b1;
                    end else begin
                        r_bitCnt <= 3'd0;
                        r_state  <= IDLE;
                        r_txOut  <= 1'b1;
                        r_busy   <= 1'b0;
                    end
                end
                START: begin
                    r_bitCnt <= 3'd0;
                    r_state  <= DATA;
                    r_txOut  <= r_data[0];
                    r_busy   <= 1'b1;
                end
                DATA: begin
                    r_busy <= 1'b1;
                    if (r_bitCnt == BIT_CNT_LAST) begin
                        r_bitCnt <= 3'd0;
                        if (r_parEn) begin
                            r_state <= PARITY;
                            r_txOut <= w_parity;
                        end else begin
                            r_state <= STOP;
                            r_txOut <= 1'b1;
                        end
                    end else begin
                        r_bitCnt <= r_bitCnt + 3'd1;
                        r_txOut  <= r_data[r_bitCnt + 3'd1];
                    end
                end
                PARITY: begin
                    r_bitCnt <= 3'd0;
                    r_state  <= STOP;
                    r_txOut  <= 1'b1;
                    r_busy   <= 1'b1;
                end
                default: begin
                    r_bitCnt <= 3'd0;
                    r_state  <= IDLE;
                    r_txOut  <= 1'b1;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx. A reference model holds the bits still
// to appear on the line as a queue and is compared against TX_OUT and busy
// one time unit after every rising edge.
module tb_uart_tx;

    typedef bit bitQ_t[$];

    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       TX_OUT;
    logic       busy;

    int         errors;
    int         checks;
    bitQ_t      lineQ;
    logic [10:0] capture;

    uart_tx dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    // Free-running bit clock, period 10
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Every comparison of the bench goes through here
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Whole frame as line levels in transmission order
    function automatic bitQ_t buildFrame(input logic [7:0] d, input logic pen,
                                         input logic ptyp);
        bitQ_t f;
        f.push_back(1'b0);
        for (int i = 0; i < 8; i++) f.push_back(d[i]);
        if (pen) f.push_back((^d) ^ ptyp);
        f.push_back(1'b1);
        return f;
    endfunction

    // Advance one clock, update the model from the inputs seen at the edge,
    // then compare the line and busy against it
    task automatic tick(input string tag);
        logic expTx;
        logic expBusy;
        @(posedge CLK);
        if (RST) begin
            lineQ.delete();
        end else if (DATA_VALID && lineQ.size() <= 1) begin
            lineQ = buildFrame(P_DATA, PAR_EN, PAR_TYP);
        end else if (lineQ.size() > 0) begin
            void'(lineQ.pop_front());
        end
        #1;
        expTx   = (lineQ.size() > 0) ? lineQ[0] : 1'b1;
        expBusy = (lineQ.size() > 0);
        checkOutput({tag, "_tx"}, 32'(TX_OUT), 32'(expTx));
        checkOutput({tag, "_busy"}, 32'(busy), 32'(expBusy));
        capture = {capture[9:0], TX_OUT};
    endtask

    // Drive the request inputs for the coming edge, then run that cycle
    task automatic applyStimulus(input string tag, input logic dv,
                                 input logic [7:0] d, input logic pen,
                                 input logic ptyp);
        DATA_VALID = dv;
        P_DATA     = d;
        PAR_EN     = pen;
        PAR_TYP    = ptyp;
        tick(tag);
    endtask

    // Directed scenarios followed by a randomized run
    initial begin
        errors     = 0;
        checks     = 0;
        capture    = '0;
        RST        = 1'b1;
        DATA_VALID = 1'b0;
        P_DATA     = 8'h00;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;

        #2;
        checkOutput("reset_tx", 32'(TX_OUT), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        applyStimulus("rst_hold", 1'b1, 8'hFF, 1'b1, 1'b1);
        applyStimulus("rst_hold", 1'b1, 8'hFF, 1'b1, 1'b1);
        RST = 1'b0;
        applyStimulus("idle", 1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus("idle", 1'b0, 8'h00, 1'b0, 1'b0);

        // 0xA5 even parity, literal waveform
        capture = '0;
        applyStimulus("a5_even", 1'b1, 8'hA5, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus("a5_even", 1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("a5_even_wave", 32'(capture), 32'(11'b01010010101));
        applyStimulus("a5_even_idle", 1'b0, 8'h00, 1'b0, 1'b0);

        // 0xA5 odd parity, literal waveform
        capture = '0;
        applyStimulus("a5_odd", 1'b1, 8'hA5, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) applyStimulus("a5_odd", 1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("a5_odd_wave", 32'(capture), 32'(11'b01010010111));
        applyStimulus("a5_odd_idle", 1'b0, 8'h00, 1'b0, 1'b0);

        // 0x01 without parity, literal waveform then idle
        capture = '0;
        applyStimulus("x01", 1'b1, 8'h01, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) applyStimulus("x01", 1'b0, 8'h00, 1'b1, 1'b1);
        checkOutput("x01_wave", 32'(capture[9:0]), 32'(10'b0100000001));
        applyStimulus("x01_idle", 1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("x01_idle_tx", 32'(TX_OUT), 32'd1);
        checkOutput("x01_idle_busy", 32'(busy), 32'd0);

        // Request during DATA is dropped, not queued
        applyStimulus("ign", 1'b1, 8'h3C, 1'b1, 1'b0);
        applyStimulus("ign", 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus("ign_data", 1'b1, 8'hFF, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus("ign_tail", 1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("ign_idle_tx", 32'(TX_OUT), 32'd1);
        checkOutput("ign_idle_busy", 32'(busy), 32'd0);

        // Back-to-back: request in the STOP cycle, busy must not drop
        applyStimulus("b2b", 1'b1, 8'hC3, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) applyStimulus("b2b", 1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("b2b_stop_tx", 32'(TX_OUT), 32'd1);
        applyStimulus("b2b_next", 1'b1, 8'h55, 1'b1, 1'b0);
        checkOutput("b2b_start_tx", 32'(TX_OUT), 32'd0);
        checkOutput("b2b_start_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 11; i++) applyStimulus("b2b_tail", 1'b0, 8'h00, 1'b0, 1'b0);

        // Asynchronous reset at data bit 4, then a clean 0x81 frame
        applyStimulus("arst", 1'b1, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus("arst", 1'b0, 8'h00, 1'b0, 1'b0);
        #3;
        RST = 1'b1;
        #1;
        checkOutput("arst_tx", 32'(TX_OUT), 32'd1);
        checkOutput("arst_busy", 32'(busy), 32'd0);
        applyStimulus("arst_hold", 1'b1, 8'h81, 1'b1, 1'b1);
        RST = 1'b0;
        capture = '0;
        applyStimulus("x81", 1'b1, 8'h81, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) applyStimulus("x81", 1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("x81_wave", 32'(capture), 32'(11'b01000000111));
        applyStimulus("x81_idle", 1'b0, 8'h00, 1'b0, 1'b0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            RST = ($urandom_range(0, 99) == 0);
            applyStimulus("rand", 1'($urandom_range(0, 1)), 8'($urandom),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        RST = 1'b0;
        for (int i = 0; i < 14; i++) applyStimulus("drain", 1'b0, 8'h00, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have the following ports:
  CLK         input   1  transmit bit clock; one serial bit per CLK cycle
  RST         input   1  reset, asynchronous, active-high
  P_DATA      input   8  parallel byte to transmit
  DATA_VALID  input   1  P_DATA valid; request to start a frame
  PAR_EN      input   1  1 = parity bit inserted after data
  PAR_TYP     input   1  0 = even parity, 1 = odd parity
  TX_OUT      output  1  serial line; idle level 1
  busy        output  1  1 while a frame is in progress
REQ-002 The block SHALL have one clock (CLK), and its reset (RST) SHALL be asynchronous and active-high.

Function
REQ-003 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP; all outputs SHALL be registered.
REQ-004 A request SHALL be accepted at a rising CLK edge when DATA_VALID=1 and the state is IDLE, or the state is STOP (back-to-back).
REQ-005 On acceptance, P_DATA, PAR_EN and PAR_TYP SHALL be latched; later changes on these inputs SHALL NOT affect the current frame.
REQ-006 DATA_VALID SHALL be ignored in START, DATA and PARITY; ignored requests SHALL NOT be queued.
REQ-007 Latency: TX_OUT SHALL go to 0 (start bit) for the one cycle that follows the accepting edge.
REQ-008 DATA SHALL drive the 8 latched bits LSB first, one per cycle; a 3-bit counter SHALL count 0..7, and DATA SHALL exit after bit 7.
REQ-009 After DATA the FSM SHALL go to PARITY when the latched PAR_EN=1, else directly to STOP.
REQ-010 The parity bit SHALL be the XOR of the 8 latched bits when PAR_TYP=0, and its inverse when PAR_TYP=1.
REQ-011 STOP SHALL drive TX_OUT=1 for exactly one cycle, then go to START when a request is accepted in that cycle, else to IDLE.
REQ-012 The frame length SHALL be 11 cycles with parity and 10 cycles without.
REQ-013 busy SHALL be 1 from the cycle of the start bit through the cycle of the stop bit, and 0 in IDLE.
REQ-014 busy SHALL stay 1 without a gap across back-to-back frames.
REQ-015 TX_OUT SHALL be 1 in IDLE.
REQ-016 The FSM SHALL never leave TX_OUT undriven or at X.
REQ-017 Unused state encodings SHALL recover to IDLE on the next edge.

Reset
REQ-018 While RST=1: state=IDLE, bit counter=0, TX_OUT=1, busy=0, and the latched data and configuration registers=0.
REQ-019 Assertion of RST mid-frame SHALL force TX_OUT=1 and busy=0 immediately (asynchronously) and drop the frame.
REQ-020 After RST deasserts, the first request SHALL be accepted no earlier than the first rising edge at which RST=0.

Structure
REQ-021 A shared package SHALL hold the FSM state typedef/encoding, the constants PAR_EVEN=0 and PAR_ODD=1, and DATA_WIDTH=8.
REQ-022 Parity generation SHALL be one sub-module, par_calc, with inputs latched data and PAR_TYP, and the parity bit as output.
REQ-023 The FSM, the serializer/counter and the output mux SHALL reside in uart_tx.

Verification
REQ-024 P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,0,1 (parity=0), busy high for 11 cycles.
REQ-025 P_DATA=0xA5, PAR_EN=1, PAR_TYP=1 -> parity bit=1; all other bits identical to REQ-024.
REQ-026 P_DATA=0x01, PAR_EN=0 -> 0,1,0,0,0,0,0,0,0,1 (10 cycles), then TX_OUT=1 and busy=0.
REQ-027 0x3C is accepted, and DATA_VALID=1 with 0xFF is applied during the DATA state -> 0xFF is not sent, and the line returns to idle after the 0x3C frame.
REQ-028 DATA_VALID=1 with 0x55 in the STOP cycle of the previous frame -> the start bit follows the stop bit directly, with no idle cycle and no drop of busy.
REQ-029 RST is asserted at DATA bit 4 -> TX_OUT=1 and busy=0 without waiting for CLK, and a new 0x81 frame sent after release is correct.
